// File: rtl/key_event_scheduler_if.sv
// Bundle of request, grant, event-FIFO head and status signals between the sources/consumer and the scheduler.
// No storage here; timing is set entirely by the scheduler.
// Sources hold req/code until their gnt bit is seen; the consumer pops only while evt_valid is high.
interface key_event_scheduler_if #(
    parameter int CODE_WIDTH = 8
);
    logic [2:0]            req;
    logic [CODE_WIDTH-1:0] code0;
    logic [CODE_WIDTH-1:0] code1;
    logic [CODE_WIDTH-1:0] code2;
    logic [2:0]            gnt;
    logic                  evt_valid;
    logic [CODE_WIDTH-1:0] evt_code;
    logic [1:0]            evt_src;
    logic                  evt_pop;
    logic                  irq;
    logic                  overflow;
    logic                  ovf_clr;

    // Sources and consumer side
    modport master (
        output req, code0, code1, code2, evt_pop, ovf_clr,
        input  gnt, evt_valid, evt_code, evt_src, irq, overflow
    );

    // Scheduler side
    modport slave (
        input  req, code0, code1, code2, evt_pop, ovf_clr,
        output gnt, evt_valid, evt_code, evt_src, irq, overflow
    );
endinterface

// File: rtl/key_event_scheduler.sv
// Round-robin arbiter over three event sources feeding a show-ahead FIFO, plus an irq with pop holdoff.
// Grant is combinational; a written entry is visible at the FIFO head one cycle later.
// Grants stop while the registered count is full; a request seen while full sets the sticky overflow flag.
module key_event_scheduler #(
    parameter int CODE_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int HOLDOFF    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    key_event_scheduler_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int EW = CODE_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} irq_state_t;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [1:0]     ptr_q;
    logic [1:0]     ptr_d;
    logic           overflow_q;
    irq_state_t     state_q;
    logic           irq_q;
    logic [HW-1:0]  hold_q;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [1:0]     gnt_idx;
    logic [2:0]     gnt;
    logic [EW-1:0]  wr_dat;
    logic [EW-1:0]  head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Round-robin pick: first requesting source at or after ptr, wrapping 2 -> 0; muted in reset or when full
    always_comb begin
        gnt_idx = 2'd0;
        gnt     = 3'b000;
        if (rst && !full && (bus.req != 3'b000)) begin
            case (ptr_q)
                2'd1:    gnt_idx = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
                2'd2:    gnt_idx = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
                default: gnt_idx = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
            endcase
            gnt = 3'b001 << gnt_idx;
        end
    end

    // Entry written for the granted source: {source index, code}
    always_comb begin
        case (gnt_idx)
            2'd1:    wr_dat = {2'd1, bus.code1};
            2'd2:    wr_dat = {2'd2, bus.code2};
            default: wr_dat = {2'd0, bus.code0};
        endcase
    end

    assign push    = (gnt != 3'b000);
    assign pop     = bus.evt_pop && !empty;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign ptr_d   = push ? ((gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1) : ptr_q;

    // Head is forced to zero when empty so reset and drained states present clean outputs
    assign head          = mem_q[rd_ptr_q];
    assign bus.gnt       = gnt;
    assign bus.evt_valid = !empty;
    assign bus.evt_code  = empty ? '0 : head[CODE_WIDTH-1:0];
    assign bus.evt_src   = empty ? 2'd0 : head[EW-1:CODE_WIDTH];
    assign bus.irq       = irq_q;
    assign bus.overflow  = overflow_q;

    // FIFO storage; no reset needed since the count gates visibility and push is muted during reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ptr_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sticky overflow: a lost request wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (full && (bus.req != 3'b000)) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // irq FSM: raise while events pend, drop for HOLDOFF cycles after a pop before re-raising
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (pop) begin
                        state_q <= HOLD;
                        irq_q   <= 1'b0;
                        hold_q  <= HW'(HOLDOFF - 1);
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_q <= empty ? IDLE : ASSERT;
                        irq_q   <= !empty;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
